// File: rtl/vending_multi_if.sv
// vending_multi_if: coin/selection inputs and vend, change and status outputs of vending_multi.
// The bench drives through master; the controller attaches as slave.
interface vending_multi_if #(
    parameter int NUM_ITEMS = 4,
    parameter int ITEM_W    = 2,
    parameter int CREDIT_W  = 8
);
    logic [1:0]           coinn;
    logic [ITEM_W-1:0]    sel;
    logic                 buy;
    logic                 cancel;
    logic                 out;
    logic [ITEM_W-1:0]    out_item;
    logic [1:0]           changee;
    logic                 coin_reject;
    logic                 busy;
    logic [CREDIT_W-1:0]  credit;
    logic [NUM_ITEMS-1:0] sold_out;

    modport master (
        output coinn, sel, buy, cancel,
        input  out, out_item, changee, coin_reject, busy, credit, sold_out
    );

    modport slave (
        input  coinn, sel, buy, cancel,
        output out, out_item, changee, coin_reject, busy, credit, sold_out
    );
endinterface

// File: rtl/vending_multi.sv
// vending_multi: multi-item vending controller with per-item prices and largest-first change.
// Define VEND_STOCK_EN to add per-item stock counters, sold-out flags and sold-out buy blocking.
module vending_multi #(
    parameter int NUM_ITEMS  = 4,
    parameter int ITEM_W     = 2,
    parameter int CREDIT_W   = 8,
    parameter int CREDIT_MAX = 100,
    parameter int COIN1_VAL  = 5,
    parameter int COIN2_VAL  = 10,
    parameter int COIN3_VAL  = 25,
    parameter int PRICE_BASE = 15,
    parameter int PRICE_STEP = 5,
    parameter int STOCK_INIT = 3
) (
    input  logic           clk,
    input  logic           reset,
    vending_multi_if.slave bus
);
    typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

    localparam logic [CREDIT_W-1:0] C1      = CREDIT_W'(COIN1_VAL);
    localparam logic [CREDIT_W-1:0] C2      = CREDIT_W'(COIN2_VAL);
    localparam logic [CREDIT_W-1:0] C3      = CREDIT_W'(COIN3_VAL);
    localparam logic [CREDIT_W-1:0] PRICE_B = CREDIT_W'(PRICE_BASE);
    localparam logic [CREDIT_W-1:0] PRICE_S = CREDIT_W'(PRICE_STEP);
    localparam logic [CREDIT_W:0]   CMAX    = (CREDIT_W+1)'(CREDIT_MAX);

    if (ITEM_W != $clog2(NUM_ITEMS) || CREDIT_MAX >= 2**CREDIT_W || STOCK_INIT > 255) begin : g_param_check
        $error("vending_multi: inconsistent parameter set");
    end

    function automatic logic [1:0] largest_coin(input logic [CREDIT_W-1:0] amt);
        logic [1:0] code;
        code = 2'b00;
        if (amt >= C3)      code = 2'b11;
        else if (amt >= C2) code = 2'b10;
        else if (amt >= C1) code = 2'b01;
        return code;
    endfunction

    function automatic logic [CREDIT_W-1:0] coin_val(input logic [1:0] code);
        logic [CREDIT_W-1:0] v;
        case (code)
            2'b01:   v = C1;
            2'b10:   v = C2;
            2'b11:   v = C3;
            default: v = '0;
        endcase
        return v;
    endfunction

    state_t              state, state_next;
    logic [CREDIT_W-1:0] credit_q, credit_next;
    logic [ITEM_W-1:0]   item_q, item_next;
    logic                out_q, out_next;
    logic [1:0]          changee_q, changee_next;
    logic                reject_q, reject_next;
    logic                busy_q;
    logic                vend_go;
    logic [1:0]          change_coin;

    logic [CREDIT_W:0]   sum;
    logic                coin_ok;
    logic [CREDIT_W-1:0] credit_acc;
    logic [CREDIT_W-1:0] price;
    logic                avail;

    // The saturation test is done one bit wider so a large coin can never wrap past CREDIT_MAX.
    assign sum        = {1'b0, credit_q} + {1'b0, coin_val(bus.coinn)};
    assign coin_ok    = (bus.coinn != 2'b00) && (sum <= CMAX);
    assign credit_acc = coin_ok ? sum[CREDIT_W-1:0] : credit_q;
    assign price      = PRICE_B + CREDIT_W'(bus.sel) * PRICE_S;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            credit_q  <= '0;
            item_q    <= '0;
            out_q     <= 1'b0;
            changee_q <= 2'b00;
            reject_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_next;
            credit_q  <= credit_next;
            item_q    <= item_next;
            out_q     <= out_next;
            changee_q <= changee_next;
            reject_q  <= reject_next;
            busy_q    <= (state_next != IDLE);
        end
    end

    // Affordability uses the credit held before this cycle's coin; the coin itself still counts.
    always_comb begin
        state_next  = state;
        credit_next = credit_q;
        item_next   = item_q;
        vend_go     = 1'b0;
        change_coin = 2'b00;
        case (state)
            IDLE: begin
                credit_next = credit_acc;
                if (bus.buy && (credit_q >= price) && avail) begin
                    state_next  = VEND;
                    item_next   = bus.sel;
                    credit_next = credit_acc - price;
                    vend_go     = 1'b1;
                end else if (bus.cancel && !bus.buy && (credit_acc != '0)) begin
                    state_next  = CHANGE;
                    change_coin = largest_coin(credit_acc);
                    credit_next = credit_acc - coin_val(change_coin);
                end
            end
            VEND: begin
                if (credit_q != '0) begin
                    state_next  = CHANGE;
                    change_coin = largest_coin(credit_q);
                    credit_next = credit_q - coin_val(change_coin);
                end else begin
                    state_next = IDLE;
                end
            end
            CHANGE: begin
                if (credit_q < C1) begin
                    state_next  = IDLE;
                    credit_next = '0;
                end else begin
                    change_coin = largest_coin(credit_q);
                    credit_next = credit_q - coin_val(change_coin);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_next     = vend_go;
        changee_next = change_coin;
        reject_next  = (bus.coinn != 2'b00) && ((state != IDLE) || !coin_ok);
    end

    assign bus.out         = out_q;
    assign bus.out_item    = item_q;
    assign bus.changee     = changee_q;
    assign bus.coin_reject = reject_q;
    assign bus.busy        = busy_q;
    assign bus.credit      = credit_q;

`ifdef VEND_STOCK_EN
    logic [7:0]           stock [NUM_ITEMS];
    logic [NUM_ITEMS-1:0] sold_out_q;

    assign avail = (stock[bus.sel] != 8'd0);

    // Stock is taken when the purchase is accepted, so sold_out is already valid during out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock[i] <= 8'(STOCK_INIT);
            end
            sold_out_q <= (STOCK_INIT == 0) ? '1 : '0;
        end else if (vend_go) begin
            stock[bus.sel]      <= stock[bus.sel] - 8'd1;
            sold_out_q[bus.sel] <= (stock[bus.sel] == 8'd1);
        end
    end

    assign bus.sold_out = sold_out_q;
`else
    assign avail        = 1'b1;
    assign bus.sold_out = '0;
`endif
endmodule

// File: tb/tb_vending_multi.sv
// tb_vending_multi: directed scenarios plus randomized transactions against a credit/stock model.
// Define VEND_STOCK_EN to build the DUT with stock counters (STOCK_INIT=1) and run the stock scenario.
module tb_vending_multi;
    localparam int NUM_ITEMS  = 4;
    localparam int ITEM_W     = 2;
    localparam int CREDIT_W   = 8;
    localparam int CREDIT_MAX = 100;
`ifdef VEND_STOCK_EN
    localparam int STOCK_INIT = 1;
`else
    localparam int STOCK_INIT = 3;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   m_credit;
    int   m_stock [NUM_ITEMS];

    vending_multi_if #(.NUM_ITEMS(NUM_ITEMS), .ITEM_W(ITEM_W), .CREDIT_W(CREDIT_W)) bus ();

    vending_multi #(
        .NUM_ITEMS(NUM_ITEMS), .ITEM_W(ITEM_W), .CREDIT_W(CREDIT_W), .CREDIT_MAX(CREDIT_MAX),
        .COIN1_VAL(5), .COIN2_VAL(10), .COIN3_VAL(25), .PRICE_BASE(15), .PRICE_STEP(5),
        .STOCK_INIT(STOCK_INIT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic int coin_value(input int code);
        case (code)
            1: return 5;
            2: return 10;
            3: return 25;
            default: return 0;
        endcase
    endfunction

    function automatic int largest_code(input int amt);
        if (amt >= 25) return 3;
        if (amt >= 10) return 2;
        if (amt >= 5)  return 1;
        return 0;
    endfunction

    function automatic int price_of(input int s);
        return 15 + 5 * s;
    endfunction

    function automatic bit in_stock(input int s);
`ifdef VEND_STOCK_EN
        return m_stock[s] > 0;
`else
        return s >= 0;
`endif
    endfunction

    // One cycle of inputs, then outputs are sampled 1ns after the clock edge.
    task automatic apply_stimulus(input int coin, input bit buy, input int sel, input bit cancel);
        bus.coinn  = 2'(coin);
        bus.buy    = buy;
        bus.sel    = ITEM_W'(sel);
        bus.cancel = cancel;
        @(posedge clk);
        #1;
        bus.coinn  = 2'b00;
        bus.buy    = 1'b0;
        bus.cancel = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.coinn = 2'b00; bus.buy = 1'b0; bus.cancel = 1'b0; bus.sel = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        m_credit = 0;
        for (int i = 0; i < NUM_ITEMS; i++) m_stock[i] = STOCK_INIT;
    endtask

    // Model of one IDLE-state cycle: coin crediting/saturation, purchase or refund decision.
    task automatic model_idle(input int coin, input bit buy, input int sel, input bit cancel,
                              output bit rej, output bit vend, output bit refund);
        int acc;
        acc = m_credit;
        rej = 1'b0; vend = 1'b0; refund = 1'b0;
        if (coin != 0) begin
            if (m_credit + coin_value(coin) <= CREDIT_MAX) acc = m_credit + coin_value(coin);
            else rej = 1'b1;
        end
        if (buy && m_credit >= price_of(sel) && in_stock(sel)) begin
            vend = 1'b1;
            m_credit = acc - price_of(sel);
            m_stock[sel]--;
        end else if (cancel && !buy && acc > 0) begin
            refund = 1'b1;
            m_credit = acc;
        end else begin
            m_credit = acc;
        end
    endtask

    task automatic test_reset();
        do_reset();
        apply_stimulus(3, 0, 0, 0);
        apply_stimulus(0, 1, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        n_compared++; if (bus.credit !== 8'd0) begin n_mismatched++; $display("[TB] FAIL reset_credit: got %0d expected 0", bus.credit); end
        n_compared++; if (bus.out !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_out: got %0d expected 0", bus.out); end
        n_compared++; if (bus.out_item !== 2'd0) begin n_mismatched++; $display("[TB] FAIL reset_out_item: got %0d expected 0", bus.out_item); end
        n_compared++; if (bus.changee !== 2'b00) begin n_mismatched++; $display("[TB] FAIL reset_changee: got %0d expected 0", bus.changee); end
        n_compared++; if (bus.coin_reject !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_reject: got %0d expected 0", bus.coin_reject); end
        n_compared++; if (bus.busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %0d expected 0", bus.busy); end
        n_compared++; if (bus.sold_out !== 4'b0000) begin n_mismatched++; $display("[TB] FAIL reset_sold_out: got %b expected 0000", bus.sold_out); end
    endtask

    task automatic test_vend_change();
        do_reset();
        apply_stimulus(2, 0, 0, 0);
        apply_stimulus(2, 0, 0, 0);
        n_compared++; if (bus.credit !== 8'd20) begin n_mismatched++; $display("[TB] FAIL v1_credit: got %0d expected 20", bus.credit); end
        apply_stimulus(0, 1, 0, 0);
        n_compared++; if (bus.out !== 1'b1 || bus.out_item !== 2'd0) begin n_mismatched++; $display("[TB] FAIL v1_out: got out=%0d item=%0d expected out=1 item=0", bus.out, bus.out_item); end
        apply_stimulus(0, 0, 0, 0);
        n_compared++; if (bus.changee !== 2'b01 || bus.out !== 1'b0) begin n_mismatched++; $display("[TB] FAIL v1_change: got changee=%0d out=%0d expected changee=1 out=0", bus.changee, bus.out); end
        n_compared++; if (bus.credit !== 8'd0) begin n_mismatched++; $display("[TB] FAIL v1_credit_after: got %0d expected 0", bus.credit); end
        apply_stimulus(0, 0, 0, 0);
        n_compared++; if (bus.changee !== 2'b00 || bus.busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL v1_done: got changee=%0d busy=%0d expected 0/0", bus.changee, bus.busy); end

        do_reset();
        apply_stimulus(3, 0, 0, 0);
        apply_stimulus(3, 0, 0, 0);
        apply_stimulus(0, 1, 3, 0);
        n_compared++; if (bus.out !== 1'b1 || bus.out_item !== 2'd3) begin n_mismatched++; $display("[TB] FAIL v2_out: got out=%0d item=%0d expected out=1 item=3", bus.out, bus.out_item); end
        n_compared++; if (bus.credit !== 8'd20) begin n_mismatched++; $display("[TB] FAIL v2_credit: got %0d expected 20", bus.credit); end
        apply_stimulus(0, 0, 0, 0);
        n_compared++; if (bus.changee !== 2'b10) begin n_mismatched++; $display("[TB] FAIL v2_change1: got %0d expected 2", bus.changee); end
        apply_stimulus(0, 0, 0, 0);
        n_compared++; if (bus.changee !== 2'b10 || bus.credit !== 8'd0) begin n_mismatched++; $display("[TB] FAIL v2_change2: got changee=%0d credit=%0d expected 2/0", bus.changee, bus.credit); end
        apply_stimulus(0, 0, 0, 0);
        n_compared++; if (bus.changee !== 2'b00 || bus.busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL v2_done: got changee=%0d busy=%0d expected 0/0", bus.changee, bus.busy); end
    endtask

    task automatic test_cancel();
        do_reset();
        apply_stimulus(3, 0, 0, 0);
        apply_stimulus(2, 0, 0, 0);
        apply_stimulus(0, 0, 0, 1);
        n_compared++; if (bus.changee !== 2'b11 || bus.out !== 1'b0) begin n_mismatched++; $display("[TB] FAIL c_change1: got changee=%0d out=%0d expected 3/0", bus.changee, bus.out); end
        apply_stimulus(0, 0, 0, 0);
        n_compared++; if (bus.changee !== 2'b10 || bus.credit !== 8'd0) begin n_mismatched++; $display("[TB] FAIL c_change2: got changee=%0d credit=%0d expected 2/0", bus.changee, bus.credit); end
        apply_stimulus(0, 0, 0, 0);
        n_compared++; if (bus.changee !== 2'b00 || bus.busy !== 1'b0 || bus.out !== 1'b0) begin n_mismatched++; $display("[TB] FAIL c_done: got changee=%0d busy=%0d out=%0d expected 0/0/0", bus.changee, bus.busy, bus.out); end
    endtask

    task automatic test_insufficient_saturation();
        int exp_credit;
        bit exp_rej;
        int codes [4] = '{3, 3, 3, 2};
        do_reset();
        apply_stimulus(2, 0, 0, 0);
        apply_stimulus(0, 1, 0, 0);
        n_compared++; if (bus.out !== 1'b0 || bus.busy !== 1'b0 || bus.credit !== 8'd10) begin n_mismatched++; $display("[TB] FAIL s_nobuy: got out=%0d busy=%0d credit=%0d expected 0/0/10", bus.out, bus.busy, bus.credit); end
        exp_credit = 10;
        for (int i = 0; i < 5; i++) begin
            exp_rej = (exp_credit + 25 > CREDIT_MAX);
            if (!exp_rej) exp_credit += 25;
            apply_stimulus(3, 0, 0, 0);
            n_compared++; if (bus.credit !== 8'(exp_credit) || bus.coin_reject !== exp_rej) begin n_mismatched++; $display("[TB] FAIL s_coin%0d: got credit=%0d rej=%0d expected %0d/%0d", i, bus.credit, bus.coin_reject, exp_credit, exp_rej); end
        end
        apply_stimulus(0, 0, 0, 0);
        n_compared++; if (bus.coin_reject !== 1'b0 || bus.credit !== 8'd85) begin n_mismatched++; $display("[TB] FAIL s_hold: got rej=%0d credit=%0d expected 0/85", bus.coin_reject, bus.credit); end
        apply_stimulus(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            n_compared++; if (bus.changee !== 2'(codes[i])) begin n_mismatched++; $display("[TB] FAIL s_refund%0d: got %0d expected %0d", i, bus.changee, codes[i]); end
            apply_stimulus(0, 0, 0, 0);
        end
        n_compared++; if (bus.changee !== 2'b00 || bus.busy !== 1'b0 || bus.credit !== 8'd0) begin n_mismatched++; $display("[TB] FAIL s_done: got changee=%0d busy=%0d credit=%0d expected 0/0/0", bus.changee, bus.busy, bus.credit); end
    endtask

    task automatic test_reset_mid_change();
        do_reset();
        apply_stimulus(3, 0, 0, 0);
        apply_stimulus(3, 0, 0, 0);
        apply_stimulus(0, 1, 3, 0);
        apply_stimulus(0, 0, 0, 0);
        n_compared++; if (bus.changee !== 2'b10 || bus.busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL r_pre: got changee=%0d busy=%0d expected 2/1", bus.changee, bus.busy); end
        #2;
        reset = 1'b0;
        #1;
        n_compared++; if (bus.changee !== 2'b00 || bus.credit !== 8'd0 || bus.busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL r_async: got changee=%0d credit=%0d busy=%0d expected 0/0/0", bus.changee, bus.credit, bus.busy); end
        @(posedge clk); #1;
        reset = 1'b1;
        apply_stimulus(0, 0, 0, 0);
        n_compared++; if (bus.changee !== 2'b00 || bus.busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL r_after: got changee=%0d busy=%0d expected 0/0", bus.changee, bus.busy); end
        m_credit = 0;
        for (int i = 0; i < NUM_ITEMS; i++) m_stock[i] = STOCK_INIT;
    endtask

`ifdef VEND_STOCK_EN
    task automatic test_stock();
        do_reset();
        apply_stimulus(3, 0, 0, 0);
        apply_stimulus(2, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0);
        apply_stimulus(0, 1, 1, 0);
        n_compared++; if (bus.out !== 1'b1 || bus.out_item !== 2'd1) begin n_mismatched++; $display("[TB] FAIL st_out: got out=%0d item=%0d expected 1/1", bus.out, bus.out_item); end
        n_compared++; if (bus.sold_out !== 4'b0010) begin n_mismatched++; $display("[TB] FAIL st_sold_out: got %b expected 0010", bus.sold_out); end
        apply_stimulus(0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0);
        n_compared++; if (bus.busy !== 1'b0 || bus.credit !== 8'd0) begin n_mismatched++; $display("[TB] FAIL st_change: got busy=%0d credit=%0d expected 0/0", bus.busy, bus.credit); end
        apply_stimulus(2, 0, 0, 0);
        apply_stimulus(2, 0, 0, 0);
        apply_stimulus(0, 1, 1, 0);
        n_compared++; if (bus.out !== 1'b0 || bus.busy !== 1'b0 || bus.credit !== 8'd20) begin n_mismatched++; $display("[TB] FAIL st_blocked: got out=%0d busy=%0d credit=%0d expected 0/0/20", bus.out, bus.busy, bus.credit); end
    endtask
`endif

    task automatic test_random();
        bit rej, vend, refund, buy, cancel;
        int coin, sel, rem, exp_code;
        logic [NUM_ITEMS-1:0] exp_so;
        do_reset();
        for (int t = 0; t < 80; t++) begin
            for (int k = $urandom_range(0, 4); k > 0; k--) begin
                coin = $urandom_range(0, 3);
                model_idle(coin, 0, 0, 0, rej, vend, refund);
                apply_stimulus(coin, 0, 0, 0);
                n_compared++; if (bus.credit !== 8'(m_credit) || bus.coin_reject !== rej) begin n_mismatched++; $display("[TB] FAIL rnd_coin: got credit=%0d rej=%0d expected %0d/%0d", bus.credit, bus.coin_reject, m_credit, rej); end
            end
            coin = $urandom_range(0, 3); sel = $urandom_range(0, 3);
            buy = 1'($urandom_range(0, 1)); cancel = 1'($urandom_range(0, 1));
            model_idle(coin, buy, sel, cancel, rej, vend, refund);
            apply_stimulus(coin, buy, sel, cancel);
            rem = m_credit;
            exp_code = 0;
            if (refund) begin
                exp_code = largest_code(rem);
                rem -= coin_value(exp_code);
            end
            exp_so = '0;
`ifdef VEND_STOCK_EN
            for (int i = 0; i < NUM_ITEMS; i++) exp_so[i] = (m_stock[i] == 0);
`endif
            n_compared++; if (bus.out !== vend || bus.coin_reject !== rej || bus.busy !== (vend | refund)) begin n_mismatched++; $display("[TB] FAIL rnd_action: got out=%0d rej=%0d busy=%0d expected %0d/%0d/%0d", bus.out, bus.coin_reject, bus.busy, vend, rej, vend | refund); end
            n_compared++; if (bus.changee !== 2'(exp_code) || bus.credit !== 8'(rem) || bus.sold_out !== exp_so) begin n_mismatched++; $display("[TB] FAIL rnd_state: got changee=%0d credit=%0d sold_out=%b expected %0d/%0d/%b", bus.changee, bus.credit, bus.sold_out, exp_code, rem, exp_so); end
            if (vend) begin
                n_compared++; if (bus.out_item !== 2'(sel)) begin n_mismatched++; $display("[TB] FAIL rnd_item: got %0d expected %0d", bus.out_item, sel); end
            end
            if (vend || refund) begin
                while (rem >= 5) begin
                    coin = $urandom_range(0, 3);
                    apply_stimulus(coin, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
                    exp_code = largest_code(rem);
                    rem -= coin_value(exp_code);
                    n_compared++; if (bus.changee !== 2'(exp_code) || bus.credit !== 8'(rem) || bus.coin_reject !== (coin != 0) || bus.out !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rnd_payout: got changee=%0d credit=%0d rej=%0d out=%0d expected %0d/%0d/%0d/0", bus.changee, bus.credit, bus.coin_reject, bus.out, exp_code, rem, coin != 0); end
                end
                coin = $urandom_range(0, 3);
                apply_stimulus(coin, 0, 0, 0);
                n_compared++; if (bus.changee !== 2'b00 || bus.busy !== 1'b0 || bus.credit !== 8'd0 || bus.coin_reject !== (coin != 0)) begin n_mismatched++; $display("[TB] FAIL rnd_end: got changee=%0d busy=%0d credit=%0d rej=%0d expected 0/0/0/%0d", bus.changee, bus.busy, bus.credit, bus.coin_reject, coin != 0); end
                m_credit = 0;
            end
        end
    endtask

    initial begin
        $display("[TB] tb_vending_multi start");
        test_reset();
        test_vend_change();
        test_cancel();
        test_insufficient_saturation();
        test_reset_mid_change();
`ifdef VEND_STOCK_EN
        test_stock();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/vending_multi.md
Name: vending_multi

Overview:
Parametrised multi-item vending controller. Successor to the single-product, fixed-price vending FSM.
- Accumulates coin credit and vends one of NUM_ITEMS products, each with its own price.
- Returns change one coin per cycle, largest denomination first.
- Supports cancel/refund and credit saturation with coin rejection.

Parameters:
NUM_ITEMS, 4, number of selectable products (power of two, >=2)
ITEM_W, 2, width of item select; must equal log2(NUM_ITEMS)
CREDIT_W, 8, credit register width
CREDIT_MAX, 100, maximum credit held; must be < 2**CREDIT_W
COIN1_VAL, 5, value of coin code 01
COIN2_VAL, 10, value of coin code 10
COIN3_VAL, 25, value of coin code 11
PRICE_BASE, 15, price of item 0
PRICE_STEP, 5, price increment per item index (price(i) = PRICE_BASE + i*PRICE_STEP)
STOCK_INIT, 3, per-item stock after reset (used only with VEND_STOCK_EN)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted at 0)
coinn  input  2  coin inserted this cycle: 00 none, 01/10/11 = COIN1/2/3
sel  input  ITEM_W  item select, sampled with buy
buy  input  1  purchase request, single-cycle pulse
cancel  input  1  refund request, single-cycle pulse
out  output  1  vend strobe, 1 cycle
out_item  output  ITEM_W  item vended, valid while out=1
changee  output  2  change coin emitted this cycle, same encoding as coinn
coin_reject  output  1  1-cycle pulse: coin this cycle not accepted
busy  output  1  1 when state != IDLE
credit  output  CREDIT_W  current credit
sold_out  output  NUM_ITEMS  per-item empty flags

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, credit=0, out=0, out_item=0, changee=00, coin_reject=0, sold_out=0.
  - Stock counters = STOCK_INIT when the macro is enabled.
  - Reset mid-CHANGE discards any remaining change.
- States: IDLE, VEND, CHANGE. All outputs registered.
- IDLE, evaluated per rising edge:
  - Coin (coinn!=00):
    - credit_next = credit + value if the sum <= CREDIT_MAX.
    - Otherwise credit is unchanged and coin_reject=1 next cycle.
  - buy with credit >= price(sel), credit compared before this cycle's coin:
    - go to VEND; latch sel.
    - credit_next = credit + accepted coin - price(sel).
  - buy with insufficient credit: ignored, no state change. Any coin is still accepted.
  - cancel (only when buy=0) with credit_next>0: go to CHANGE.
  - buy has priority over cancel.
- VEND (1 cycle):
  - out=1, out_item=latched sel.
  - Next state CHANGE if credit>0, else IDLE.
- CHANGE:
  - Each cycle emits the largest coin with value <= credit and subtracts it.
  - When credit=0, changee=00 and return to IDLE.
  - If credit>0 but < COIN1_VAL: credit forfeited (cleared), return to IDLE.
- Coins during VEND/CHANGE: not credited; coin_reject=1 next cycle. buy/cancel ignored.
- Latency: buy to out = 1 cycle. First change coin is the cycle after out. Refund's first coin is the cycle after cancel.
- All arithmetic in CREDIT_W bits, unsigned. Saturation check uses CREDIT_W+1 bits so it cannot wrap.

Optional Feature:
Macro VEND_STOCK_EN.
- Defined:
  - Per-item 8-bit stock counter, reset to STOCK_INIT.
  - A vend decrements the selected item's counter.
  - sold_out[i]=1 while stock[i]==0.
  - buy on a sold-out item is ignored; credit is unchanged.
- Undefined: no stock logic; sold_out tied to 0; every item is always available.

Test Plan:
1. Coins 10,10 (credit 20); buy sel=0 (price 15) -> next cycle out=1, out_item=0; then changee=01 for one cycle; credit 0; busy drops.
2. Coins 25,25 (50); buy sel=3 (price 30) -> out=1, out_item=3; then changee=10, 10 on consecutive cycles; IDLE.
3. Coins 25,10 (35); cancel -> changee=11 then 10; credit 0; out never asserts.
4. Credit 10; buy sel=0 -> no out; credit stays 10. Then 4x25 -> credit 85. Coin 25 -> coin_reject=1, credit 85.
5. Reset=0 asserted during the first cycle of CHANGE after test 2 -> changee=00 and credit=0 immediately; busy=0.
6. VEND_STOCK_EN, STOCK_INIT=1:
   - Credit 40; buy sel=1 (20) -> vend; change 20 returned; sold_out[1]=1.
   - Credit 20; buy sel=1 -> ignored; credit stays 20.
